// File: rtl/addsub_serial_slice.sv
// addsub_serial_slice
// Digit-serial adder/subtractor. Two WIDTH-bit operands are combined SLICE
// bits per clock through one SLICE-bit ripple adder. A registered carry links
// consecutive slices, so a full operation takes WIDTH/SLICE cycles after the
// start is accepted. Carry-out, signed overflow and zero flags are reported
// together with a one-cycle done pulse.
//
// Optional build macro: ADDSUB_SAT_EN
//   When defined, an overflowing result is clamped to the most positive or
//   most negative signed value instead of wrapping. ovf and Cout still report
//   the unsaturated outcome.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_start  operation request, sampled only while idle
//   i_op     0: A+B+Cin, 1: A+~B+Cin (Cin=1 gives A-B)
//   i_a      operand A, captured on an accepted start
//   i_b      operand B, captured on an accepted start
//   i_cin    carry into slice 0, captured on an accepted start
//   o_busy   high while slices are being processed
//   o_done   one-cycle pulse when the result becomes valid
//   o_s      result, held until the next accepted start
//   o_cout   carry out of the most significant slice
//   o_ovf    signed overflow (carry into MSB xor carry out of MSB)
//   o_zero   result equals zero
`timescale 1ns/1ps

module addsub_serial_slice #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_done;

  logic [SLICE:0]   w_sliceSum;
  logic             w_carryIntoMsb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sNext;
  logic [WIDTH-1:0] w_sFinal;

  // One slice of ripple addition on the low bits of the shift registers.
  // On the last slice, bit SLICE-1 is the operand MSB, so the carry into it
  // is recovered from the sum bit and the two operand bits.
  always_comb begin
    w_sliceSum     = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]}
                     + (SLICE+1)'(r_carry);
    w_carryIntoMsb = w_sliceSum[SLICE-1] ^ r_a[SLICE-1] ^ r_b[SLICE-1];
    w_ovf          = w_carryIntoMsb ^ w_sliceSum[SLICE];
    w_sNext        = r_s;
    w_sNext[int'(r_k)*SLICE +: SLICE] = w_sliceSum[SLICE-1:0];
    w_sFinal       = w_sNext;
`ifdef ADDSUB_SAT_EN
    // A wrapped result with MSB set means the true result overflowed upwards.
    if (w_ovf) begin
      w_sFinal = w_sliceSum[SLICE-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  // Control FSM and datapath registers. B is inverted at capture time so the
  // slice adder only ever adds; flags update only on the completion edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_a     <= i_a;
            r_b     <= i_op ? ~i_b : i_b;
            r_carry <= i_cin;
            r_k     <= '0;
            r_s     <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> SLICE;
          r_b     <= r_b >> SLICE;
          r_carry <= w_sliceSum[SLICE];
          if (r_k == LAST_K) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_s     <= w_sFinal;
            r_cout  <= w_sliceSum[SLICE];
            r_ovf   <= w_ovf;
            r_zero  <= (w_sFinal == '0);
            r_done  <= 1'b1;
          end else begin
            r_s <= w_sNext;
            r_k <= r_k + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy = (r_state == RUN);
  assign o_done = r_done;
  assign o_s    = r_s;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;
  assign o_zero = r_zero;

endmodule

// File: tb/tb_addsub_serial_slice.sv
// tb_addsub_serial_slice
// Directed bench for addsub_serial_slice. Three instances share operands and
// reset: SLICE=4, SLICE=16 and SLICE=1, each with its own start line.
// Expected values are hand-computed constants; saturated expectations are
// selected when ADDSUB_SAT_EN is defined.
`timescale 1ns/1ps

module tb_addsub_serial_slice;

  logic        clk;
  logic        rst_n;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        start4, start16, start1;

  logic        busy4, done4, cout4, ovf4, zero4;
  logic [15:0] s4;
  logic        busy16, done16, cout16, ovf16, zero16;
  logic [15:0] s16;
  logic        busy1, done1, cout1, ovf1, zero1;
  logic [15:0] s1;

  int checks = 0;
  int errors = 0;

  addsub_serial_slice #(.WIDTH(16), .SLICE(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_op(op),
    .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy4), .o_done(done4), .o_s(s4),
    .o_cout(cout4), .o_ovf(ovf4), .o_zero(zero4));

  addsub_serial_slice #(.WIDTH(16), .SLICE(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_op(op),
    .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy16), .o_done(done16), .o_s(s16),
    .o_cout(cout16), .o_ovf(ovf16), .o_zero(zero16));

  addsub_serial_slice #(.WIDTH(16), .SLICE(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_op(op),
    .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy1), .o_done(done1), .o_s(s1),
    .o_cout(cout1), .o_ovf(ovf1), .o_zero(zero1));

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one start pulse to the selected instance. Entered and left on a
  // falling edge, so the start is sampled by exactly one rising edge.
  task automatic applyStimulus(input int sel, input logic iop,
                               input logic [15:0] ia, input logic [15:0] ib,
                               input logic icin);
    op = iop; a = ia; b = ib; cin = icin;
    case (sel)
      4:       start4  = 1'b1;
      16:      start16 = 1'b1;
      default: start1  = 1'b1;
    endcase
    @(negedge clk);
    start4 = 1'b0; start16 = 1'b0; start1 = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; op = 1'b0; cin = 1'b0;
  endtask

  // Wait (bounded) on falling edges until done, counting busy cycles seen.
  task automatic waitDone(input int sel, output int busyCnt);
    logic d, bz;
    int   budget;
    busyCnt = 0;
    budget  = 0;
    while (1) begin
      case (sel)
        4:       begin d = done4;  bz = busy4;  end
        16:      begin d = done16; bz = busy16; end
        default: begin d = done1;  bz = busy1;  end
      endcase
      if (d) break;
      if (bz) busyCnt++;
      budget++;
      if (budget > 40) begin
        checks++; errors++;
        $display("[TB] FAIL done_timeout sel=%0d got no done want done within 40 cycles", sel);
        busyCnt = -1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reset values on all instances, during and just after reset.
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy4, done4, s4, cout4, ovf4, zero4} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_dut4 got b%b d%b s%h c%b o%b z%b want b0 d0 s0000 c0 o0 z1",
               busy4, done4, s4, cout4, ovf4, zero4);
    end
    checks++;
    if ({busy16, done16, s16, zero16, busy1, done1, s1, zero1} !==
        {1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_dut16_dut1 got s16=%h z16=%b s1=%h z1=%b want 0000 1 0000 1",
               s16, zero16, s1, zero1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release got busy=%b done=%b want 0 0", busy4, done4);
    end
  endtask

  // Plain addition: busy for exactly 4 cycles, one-cycle done, result held.
  task automatic test_add;
    int n;
    applyStimulus(4, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
    waitDone(4, n);
    checks++;
    if (n !== 4) begin
      errors++; $display("[TB] FAIL add_busy_cycles got %0d want 4", n);
    end
    checks++;
    if ({s4, cout4, ovf4, zero4} !== {16'h2233, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL add_result got s=%h c=%b o=%b z=%b want s=2233 c0 o0 z0",
               s4, cout4, ovf4, zero4);
    end
    @(negedge clk);
    checks++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("[TB] FAIL add_done_pulse got done=%b busy=%b want 0 0", done4, busy4);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (s4 !== 16'h2233) begin
      errors++; $display("[TB] FAIL add_hold got %h want 2233", s4);
    end
  endtask

  // Subtraction with borrow; S must clear on accept while flags hold.
  task automatic test_sub;
    int n;
    applyStimulus(4, 1'b1, 16'h0005, 16'h0007, 1'b1);
    checks++;
    if (s4 !== 16'h0000 || zero4 !== 1'b0 || busy4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sub_accept got s=%h z=%b busy=%b want s=0000 z0 busy1", s4, zero4, busy4);
    end
    waitDone(4, n);
    checks++;
    if ({s4, cout4, ovf4, zero4} !== {16'hFFFE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sub_result got s=%h c=%b o=%b z=%b want s=fffe c0 o0 z0",
               s4, cout4, ovf4, zero4);
    end
  endtask

  // Signed overflow on 0x7FFF+1, optionally saturated.
  task automatic test_overflow;
    int n;
    logic [15:0] expS;
`ifdef ADDSUB_SAT_EN
    expS = 16'h7FFF;
`else
    expS = 16'h8000;
`endif
    applyStimulus(4, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
    waitDone(4, n);
    checks++;
    if ({s4, cout4, ovf4, zero4} !== {expS, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ovf_pos got s=%h c=%b o=%b z=%b want s=%h c0 o1 z0",
               s4, cout4, ovf4, zero4, expS);
    end
  endtask

  // Equal operands subtract to zero with carry out set.
  task automatic test_zero;
    int n;
    applyStimulus(4, 1'b1, 16'h1234, 16'h1234, 1'b1);
    waitDone(4, n);
    checks++;
    if ({s4, cout4, ovf4, zero4} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL zero_result got s=%h c=%b o=%b z=%b want s=0000 c1 o0 z1",
               s4, cout4, ovf4, zero4);
    end
  endtask

  // A second start while busy must be ignored.
  task automatic test_start_while_busy;
    int n;
    applyStimulus(4, 1'b0, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    op = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    waitDone(4, n);
    checks++;
    if (n !== 2 || s4 !== 16'h3333) begin
      errors++;
      $display("[TB] FAIL busy_ignore got remaining=%0d s=%h want remaining=2 s=3333", n, s4);
    end
    @(negedge clk);
  endtask

  // Reset mid-run clears outputs immediately and no done follows.
  task automatic test_reset_midrun;
    int seenDone;
    applyStimulus(4, 1'b0, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy4 !== 1'b0 || s4 !== 16'h0000 || zero4 !== 1'b1 || done4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got busy=%b s=%h z=%b d=%b want busy0 s=0000 z1 d0",
               busy4, s4, zero4, done4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seenDone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4 || busy4) seenDone++;
    end
    checks++;
    if (seenDone !== 0) begin
      errors++; $display("[TB] FAIL reset_no_done got %0d active cycles want 0", seenDone);
    end
  endtask

  // Start accepted in the done cycle; repeated for SLICE=4, 16 and 1.
  task automatic test_back_to_back;
    int n;
    logic [15:0] expS;
    // SLICE=4
    applyStimulus(4, 1'b0, 16'h00FF, 16'h0F01, 1'b0);
    waitDone(4, n);
    checks++;
    if (s4 !== 16'h1000 || done4 !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b4_first got s=%h done=%b want 1000 1", s4, done4);
    end
    applyStimulus(4, 1'b0, 16'h0001, 16'h0001, 1'b0);
    checks++;
    if (done4 !== 1'b0 || busy4 !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b4_accept got done=%b busy=%b want 0 1", done4, busy4);
    end
    waitDone(4, n);
    checks++;
    if (n !== 4 || s4 !== 16'h0002) begin
      errors++; $display("[TB] FAIL b2b4_second got cycles=%0d s=%h want 4 0002", n, s4);
    end
    // SLICE=16: carry-in wraps 0xFFFF to zero
    applyStimulus(16, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    waitDone(16, n);
    checks++;
    if (n !== 1 || {s16, cout16, ovf16, zero16} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL slice16_cin got cycles=%0d s=%h c=%b o=%b z=%b want 1 0000 c1 o0 z1",
               n, s16, cout16, ovf16, zero16);
    end
    applyStimulus(16, 1'b0, 16'h0001, 16'h0001, 1'b0);
    waitDone(16, n);
    checks++;
    if (n !== 1 || s16 !== 16'h0002 || zero16 !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b16 got cycles=%0d s=%h z=%b want 1 0002 0", n, s16, zero16);
    end
    // SLICE=1: 0x8000-1 overflows negatively
`ifdef ADDSUB_SAT_EN
    expS = 16'h8000;
`else
    expS = 16'h7FFF;
`endif
    applyStimulus(1, 1'b1, 16'h8000, 16'h0001, 1'b1);
    waitDone(1, n);
    checks++;
    if (n !== 16 || {s1, cout1, ovf1, zero1} !== {expS, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL slice1_ovf_neg got cycles=%0d s=%h c=%b o=%b z=%b want 16 %h c1 o1 z0",
               n, s1, cout1, ovf1, zero1, expS);
    end
    applyStimulus(1, 1'b0, 16'h0001, 16'h0001, 1'b0);
    waitDone(1, n);
    checks++;
    if (n !== 16 || {s1, ovf1} !== {16'h0002, 1'b0}) begin
      errors++; $display("[TB] FAIL b2b1 got cycles=%0d s=%h o=%b want 16 0002 0", n, s1, ovf1);
    end
  endtask

  // Test sequence.
  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; start16 = 1'b0; start1 = 1'b0;
    op = 1'b0; a = '0; b = '0; cin = 1'b0;
    $display("[TB] start");
    test_reset;
    test_add;
    test_sub;
    test_overflow;
    test_zero;
    test_start_while_busy;
    test_reset_midrun;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
